opb_cmd_engine: RTL and testbench

Parametrised byte-stream-to-OPB command engine, the successor to the single-word OPB emulation target. It sits between the UART message buffer FIFOs (RX/TX byte FIFOs) and the OPB master port. It decodes framed read/write commands with configurable address/data width and bursts up to `MAX_BURST` words, with or without address auto-increment. It returns read data or a status byte, aborts stalled frames on an inter-byte timeout, and counts errors.

---
 rtl/opb_cmd_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_opb_cmd_engine.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_cmd_engine.sv
// Byte-stream command engine: turns framed read/write commands from the RX FIFO into
// OPB single or burst accesses, and returns read data or a status byte on the TX FIFO.
module opb_cmd_engine #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_BURST   = 16,
    parameter int ADDR_STEP   = DATA_W / 8,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST_N,
    output logic              RX_FIFO_RD,
    input  logic [7:0]        RX_FIFO_DATA,
    input  logic              RX_FIFO_EMPTY,
    output logic              TX_FIFO_WR,
    output logic [7:0]        TX_FIFO_DATA,
    input  logic              TX_FIFO_FULL,
    output logic              OPB_CLK,
    output logic              OPB_RST,
    output logic [ADDR_W-1:0] OPB_ADDR,
    output logic [DATA_W-1:0] OPB_DO,
    input  logic [DATA_W-1:0] OPB_DI,
    output logic              OPB_WE,
    output logic              OPB_RE,
    output logic              BUSY,
    output logic [7:0]        ERR_CNT
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0]        A_LAST  = 3'(ADDR_W / 8 - 1);
    localparam logic [2:0]        D_LAST  = 3'(DATA_W / 8 - 1);
    localparam logic [6:0]        MAX_N   = 7'(MAX_BURST);
    localparam logic [2:0]        LAT_N   = 3'(RD_LAT);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WR_BUS, S_RD_BUS, S_RD_WAIT, S_TX_DATA, S_STAT, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              run_q, run_d;
    logic              wr_q, wr_d;
    logic              fix_q, fix_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        byte_q, byte_d;
    logic [2:0]        lat_q, lat_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [7:0]        err_q, err_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odo_q, odo_d;

    logic              rx_rd, tx_wr;
    logic [7:0]        tx_byte;
    logic [6:0]        n_cmd;
    logic [ADDR_W-1:0] addr_shift, addr_next;
    logic [DATA_W-1:0] data_shift;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign n_cmd      = {1'b0, RX_FIFO_DATA[5:0]} + 7'd1;
    assign addr_shift = ADDR_W'({addr_q, RX_FIFO_DATA});
    assign data_shift = DATA_W'({data_q, RX_FIFO_DATA});
    assign addr_next  = fix_q ? addr_q : addr_q + STEP;

    always_comb begin
        state_d = state_q;
        run_d   = 1'b1;
        wr_d    = wr_q;
        fix_d   = fix_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        byte_d  = byte_q;
        lat_d   = lat_q;
        to_d    = to_q;
        err_d   = err_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        oaddr_d = oaddr_q;
        odo_d   = odo_q;
        rx_rd   = 1'b0;
        tx_wr   = 1'b0;
        tx_byte = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                byte_d = '0;
                to_d   = '0;
                // run_q keeps the pop strobe low in the first cycle out of reset
                if (run_q && !RX_FIFO_EMPTY) begin
                    rx_rd = 1'b1;
                    if (n_cmd > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        wr_d    = RX_FIFO_DATA[7];
                        fix_d   = RX_FIFO_DATA[6];
                        cnt_d   = n_cmd;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (!RX_FIFO_EMPTY) begin
                    rx_rd  = 1'b1;
                    to_d   = '0;
                    addr_d = addr_shift;
                    if (byte_q == A_LAST) begin
                        byte_d = '0;
                        if (wr_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_RD_BUS;
                            re_d    = 1'b1;
                            oaddr_d = addr_shift;
                        end
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            S_WDATA: begin
                if (!RX_FIFO_EMPTY) begin
                    rx_rd  = 1'b1;
                    to_d   = '0;
                    data_d = data_shift;
                    if (byte_q == D_LAST) begin
                        byte_d  = '0;
                        state_d = S_WR_BUS;
                        we_d    = 1'b1;
                        oaddr_d = addr_q;
                        odo_d   = data_shift;
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    // an unfinished word is dropped without touching the bus
                    state_d = S_ERR;
                end else begin
                    to_d = to_q + TO_ONE;
                end
            end
            S_WR_BUS: begin
                to_d    = '0;
                cnt_d   = cnt_q - 7'd1;
                addr_d  = addr_next;
                state_d = (cnt_q == 7'd1) ? S_STAT : S_WDATA;
            end
            S_RD_BUS: begin
                lat_d   = 3'd1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == LAT_N) begin
                    data_d  = OPB_DI;
                    byte_d  = '0;
                    state_d = S_TX_DATA;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_TX_DATA: begin
                tx_byte = data_q[DATA_W-1 -: 8];
                if (!TX_FIFO_FULL) begin
                    tx_wr  = 1'b1;
                    data_d = DATA_W'({data_q, 8'h00});
                    if (byte_q == D_LAST) begin
                        byte_d = '0;
                        cnt_d  = cnt_q - 7'd1;
                        addr_d = addr_next;
                        if (cnt_q == 7'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_RD_BUS;
                            re_d    = 1'b1;
                            oaddr_d = addr_next;
                        end
                    end else begin
                        byte_d = byte_q + 3'd1;
                    end
                end
            end
            S_STAT: begin
                tx_byte = 8'hA5;
                if (!TX_FIFO_FULL) begin
                    tx_wr   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                tx_byte = 8'hEE;
                if (!TX_FIFO_FULL) begin
                    tx_wr   = 1'b1;
                    err_d   = sat_inc(err_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            wr_q    <= 1'b0;
            fix_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            byte_q  <= '0;
            lat_q   <= '0;
            to_q    <= '0;
            err_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            oaddr_q <= '0;
            odo_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            wr_q    <= wr_d;
            fix_q   <= fix_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            byte_q  <= byte_d;
            lat_q   <= lat_d;
            to_q    <= to_d;
            err_q   <= err_d;
            we_q    <= we_d;
            re_q    <= re_d;
            oaddr_q <= oaddr_d;
            odo_q   <= odo_d;
        end
    end

    assign RX_FIFO_RD   = rx_rd;
    assign TX_FIFO_WR   = tx_wr;
    assign TX_FIFO_DATA = tx_byte;
    assign OPB_CLK      = SYS_CLK;
    assign OPB_RST      = ~SYS_RST_N;
    assign OPB_ADDR     = oaddr_q;
    assign OPB_DO       = odo_q;
    assign OPB_WE       = we_q;
    assign OPB_RE       = re_q;
    assign BUSY         = (state_q != S_IDLE);
    assign ERR_CNT      = err_q;

endmodule

// File: tb/tb_opb_cmd_engine.sv
// Bench for opb_cmd_engine: FIFO/OPB environment plus a frame-level reference model
// that predicts the bus accesses and TX byte stream of every command.
module tb_opb_cmd_engine;
    localparam int MAXB = 16;
    localparam int RDL  = 3;
    localparam int TOC  = 40;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N = 1'b0;
    logic        RX_FIFO_RD;
    logic [7:0]  RX_FIFO_DATA = 8'h00;
    logic        RX_FIFO_EMPTY = 1'b1;
    logic        TX_FIFO_WR;
    logic [7:0]  TX_FIFO_DATA;
    logic        TX_FIFO_FULL = 1'b0;
    logic        OPB_CLK, OPB_RST;
    logic [31:0] OPB_ADDR, OPB_DO;
    logic [31:0] OPB_DI = 32'h0;
    logic        OPB_WE, OPB_RE, BUSY;
    logic [7:0]  ERR_CNT;

    opb_cmd_engine #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .RD_LAT(RDL),
                     .TIMEOUT_CYC(TOC)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST_N(SYS_RST_N),
        .RX_FIFO_RD(RX_FIFO_RD), .RX_FIFO_DATA(RX_FIFO_DATA), .RX_FIFO_EMPTY(RX_FIFO_EMPTY),
        .TX_FIFO_WR(TX_FIFO_WR), .TX_FIFO_DATA(TX_FIFO_DATA), .TX_FIFO_FULL(TX_FIFO_FULL),
        .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .OPB_ADDR(OPB_ADDR), .OPB_DO(OPB_DO),
        .OPB_DI(OPB_DI), .OPB_WE(OPB_WE), .OPB_RE(OPB_RE), .BUSY(BUSY), .ERR_CNT(ERR_CNT)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0, failures = 0, cyc = 0;
    int err_exp = 0, both_err = 0, full_err = 0, pop_err = 0;
    logic [7:0] rxq[$], exp_tx[$], obs_tx[$];
    int obs_tx_cyc[$], pop_cyc[$], acc_cyc[$];
    acc_t exp_acc[$], obs_acc[$];
    bit rnd_gap = 0, rnd_full = 0;
    int full_lo = -1, full_hi = -1;
    bit rd_pending = 0;
    logic [31:0] rd_addr;
    int rd_due = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return a ^ 32'h55AA55AA;
    endfunction

    // One clock: drive the FIFO/bus inputs after the falling edge, observe #1 later.
    task automatic cycle();
        acc_t a;
        RX_FIFO_EMPTY = (rxq.size() == 0) || (rnd_gap && $urandom_range(3) == 0);
        RX_FIFO_DATA  = (rxq.size() != 0) ? rxq[0] : 8'h00;
        TX_FIFO_FULL  = (cyc >= full_lo && cyc < full_hi) || (rnd_full && $urandom_range(3) == 0);
        if (rd_pending && cyc == rd_due) begin
            OPB_DI = rd_val(rd_addr);
            rd_pending = 0;
        end else begin
            OPB_DI = $urandom();
        end
        #1;
        if (OPB_WE && OPB_RE) both_err++;
        if (OPB_WE) begin
            a.wr = 1'b1; a.addr = OPB_ADDR; a.data = OPB_DO;
            obs_acc.push_back(a); acc_cyc.push_back(cyc);
        end
        if (OPB_RE) begin
            a.wr = 1'b0; a.addr = OPB_ADDR; a.data = 32'h0;
            obs_acc.push_back(a); acc_cyc.push_back(cyc);
            rd_pending = 1; rd_addr = OPB_ADDR; rd_due = cyc + RDL;
        end
        if (TX_FIFO_WR) begin
            if (TX_FIFO_FULL) full_err++;
            obs_tx.push_back(TX_FIFO_DATA); obs_tx_cyc.push_back(cyc);
        end
        if (RX_FIFO_RD) begin
            if (RX_FIFO_EMPTY) pop_err++;
            else begin
                void'(rxq.pop_front());
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        cyc++;
    endtask

    task automatic clear_all();
        exp_acc.delete(); obs_acc.delete(); acc_cyc.delete();
        exp_tx.delete(); obs_tx.delete(); obs_tx_cyc.delete(); pop_cyc.delete();
    endtask

    task automatic err_bump();
        exp_tx.push_back(8'hEE);
        if (err_exp < 255) err_exp++;
    endtask

    // Reference model: queue the frame bytes and predict its accesses and response.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d0);
        int n;
        logic [31:0] d, v;
        acc_t e;
        n = int'(cmd[5:0]) + 1;
        rxq.push_back(cmd);
        if (n > MAXB) begin
            err_bump();
            return;
        end
        for (int i = 3; i >= 0; i--) rxq.push_back(a[8*i +: 8]);
        for (int w = 0; w < n; w++) begin
            if (cmd[7]) begin
                d = (w == 0) ? d0 : $urandom();
                for (int i = 3; i >= 0; i--) rxq.push_back(d[8*i +: 8]);
                e.wr = 1'b1; e.addr = a; e.data = d;
            end else begin
                e.wr = 1'b0; e.addr = a; e.data = 32'h0;
                v = rd_val(a);
                for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
            end
            exp_acc.push_back(e);
            if (!cmd[6]) a = a + 32'd4;
        end
        if (cmd[7]) exp_tx.push_back(8'hA5);
    endtask

    task automatic run_frame(input string tag);
        bit done = 0;
        int nbad = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (rxq.size() == 0 && !BUSY) begin
                done = 1;
                break;
            end
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_nacc"}, obs_acc.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size() && i < obs_acc.size() && nbad == 0; i++) begin
            if (obs_acc[i] !== exp_acc[i]) nbad++;
            chk($sformatf("%s_acc%0d", tag, i), obs_acc[i], exp_acc[i]);
        end
        chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
        nbad = 0;
        for (int i = 0; i < exp_tx.size() && i < obs_tx.size() && nbad == 0; i++) begin
            if (obs_tx[i] !== exp_tx[i]) nbad++;
            chk($sformatf("%s_tx%0d", tag, i), obs_tx[i], exp_tx[i]);
        end
        chk({tag, "_errcnt"}, ERR_CNT, err_exp);
    endtask

    initial begin
        acc_t e;
        bit done;
        int re_c, dly, n;
        logic [7:0] cmd;

        // reset state
        @(negedge SYS_CLK);
        #1;
        chk("rst_strobes", {RX_FIFO_RD, TX_FIFO_WR, OPB_WE, OPB_RE, BUSY, ERR_CNT, TX_FIFO_DATA}, 0);
        chk("rst_bus", {OPB_ADDR, OPB_DO}, 0);
        chk("rst_opb_rst", OPB_RST, 1);
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        #1;
        chk("rel_opb_rst", OPB_RST, 0);
        chk("opb_clk", OPB_CLK, SYS_CLK);
        @(negedge SYS_CLK);

        // single write, defaults
        clear_all();
        send_frame(8'h80, 32'h0000_1000, 32'hDEAD_BEEF);
        run_frame("wr1");
        if (acc_cyc.size() > 0 && pop_cyc.size() >= 9 && obs_tx_cyc.size() > 0) begin
            chk("wr1_we_after_last_pop", acc_cyc[0] - pop_cyc[8], 1);
            chk("wr1_pops_back_to_back", pop_cyc[8] - pop_cyc[0], 8);
            chk("wr1_a5_after_we", obs_tx_cyc[0] - acc_cyc[0], 1);
        end

        // incrementing read burst
        clear_all();
        send_frame(8'h02, 32'h0000_2000, 32'h0);
        run_frame("rd3");
        if (acc_cyc.size() > 0 && pop_cyc.size() >= 5 && obs_tx_cyc.size() > 0) begin
            chk("rd3_re_after_last_pop", acc_cyc[0] - pop_cyc[4], 1);
            chk("rd3_first_push_lat", obs_tx_cyc[0] - acc_cyc[0], RDL + 1);
        end

        // fixed-address write burst
        clear_all();
        send_frame(8'hC1, 32'h0000_3000, 32'h1122_3344);
        run_frame("wrfix");

        // oversize command followed by a valid read
        clear_all();
        send_frame(8'h3F, 32'h0, 32'h0);
        send_frame(8'h01, 32'h0000_4000, 32'h0);
        run_frame("oversize");

        // stall mid-address until timeout
        clear_all();
        rxq.push_back(8'h80); rxq.push_back(8'h12); rxq.push_back(8'h34);
        err_bump();
        run_frame("to_addr");
        dly = (obs_tx_cyc.size() > 0 && pop_cyc.size() > 0) ? obs_tx_cyc[0] - pop_cyc[pop_cyc.size()-1] : -1;
        chk("to_addr_delay", (dly >= TOC && dly <= TOC + 2), 1);

        // stall in second word of a burst: first word stays written
        clear_all();
        rxq.push_back(8'h81);
        for (int i = 0; i < 4; i++) rxq.push_back(8'h00);
        rxq.push_back(8'hCA); rxq.push_back(8'hFE); rxq.push_back(8'hF0); rxq.push_back(8'h0D);
        rxq.push_back(8'hAB); rxq.push_back(8'hCD);
        e.wr = 1'b1; e.addr = 32'h0; e.data = 32'hCAFE_F00D;
        exp_acc.push_back(e);
        err_bump();
        run_frame("to_wdata");

        // TX FIFO full for 50 cycles during a read
        clear_all();
        full_lo = cyc + 8; full_hi = cyc + 58;
        send_frame(8'h02, 32'h0000_5000, 32'h0);
        run_frame("txfull");
        full_lo = -1; full_hi = -1;

        // address wrap-around
        clear_all();
        send_frame(8'h01, 32'hFFFF_FFFC, 32'h0);
        run_frame("wrap");
        chk("wrap_second_addr", (obs_acc.size() > 1) ? obs_acc[1].addr : 32'hDEAD_DEAD, 32'h0);

        // randomized frames with RX gaps and TX back-pressure
        rnd_gap = 1; rnd_full = 1;
        for (int f = 0; f < 25; f++) begin
            clear_all();
            n = ($urandom_range(7) == 0) ? $urandom_range(64, MAXB + 1) : $urandom_range(MAXB, 1);
            cmd = {1'($urandom_range(1)), 1'($urandom_range(1)), 6'(n - 1)};
            send_frame(cmd, $urandom(), $urandom());
            run_frame($sformatf("rnd%0d", f));
        end
        rnd_gap = 0; rnd_full = 0;

        // error counter saturation
        clear_all();
        for (int i = 0; i < 260; i++) send_frame(8'h3F | (8'($urandom()) & 8'hC0), 32'h0, 32'h0);
        run_frame("sat");
        chk("sat_value", ERR_CNT, 8'd255);

        // reset in the middle of a read burst
        clear_all();
        send_frame(8'h47, 32'h0000_6000, 32'h0);
        done = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (acc_cyc.size() > 0) begin
                done = 1;
                break;
            end
        end
        chk("mid_first_re", done, 1);
        re_c = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
        for (int i = 0; i < 20 && cyc < re_c + RDL + 5; i++) cycle();
        #1;
        chk("mid_re_before_rst", OPB_RE, 1);
        #1;
        SYS_RST_N = 1'b0;
        #1;
        chk("mid_rst_strobes", {OPB_RE, OPB_WE, TX_FIFO_WR, RX_FIFO_RD, BUSY}, 0);
        chk("mid_rst_opb_rst", OPB_RST, 1);
        chk("mid_rst_errcnt", ERR_CNT, 0);
        rxq.delete(); rd_pending = 0; err_exp = 0;
        RX_FIFO_EMPTY = 1'b1;
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        @(negedge SYS_CLK);

        clear_all();
        send_frame(8'h80, 32'h0000_7000, 32'h1234_5678);
        run_frame("post_rst");

        chk("never_we_and_re", both_err, 0);
        chk("no_push_when_full", full_err, 0);
        chk("no_pop_when_empty", pop_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
